// File: rtl/scene_sequencer.sv
// scene_sequencer: frame-rate game-state controller.
// Sequences title -> overworld <-> battle. Every scene change is a fade to black,
// a scene swap while black, then a fade back up. Decisions are taken only on
// frame ticks, which are the rising edges of VGA vsync.
module scene_sequencer #(
  parameter int         FADE_FRAMES = 2,
  parameter logic [7:0] START_KEY   = 8'h28
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        vs,
  input  logic [15:0] keycode,
  input  logic        battle_req,
  input  logic        battle_done,
  output logic [1:0]  scene,
  output logic [3:0]  fade,
  output logic        move_en,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  localparam int CW = $clog2(FADE_FRAMES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FADE_FRAMES - 1);

  localparam logic [1:0] SC_TITLE     = 2'd0;
  localparam logic [1:0] SC_OVERWORLD = 2'd1;
  localparam logic [1:0] SC_BATTLE    = 2'd2;

  typedef enum logic [2:0] {
    S_TITLE     = 3'd0,
    S_OVERWORLD = 3'd1,
    S_BATTLE    = 3'd2,
    S_FADE_OUT  = 3'd3,
    S_FADE_IN   = 3'd4
  } state_t;

  state_t        state;
  logic [1:0]    target;
  logic [CW-1:0] cnt;
  logic          vs_q;
  logic          start_q;
  logic          req_q;

  logic frame_tick;
  logic start_hit;
  logic start_edge;
  logic req_edge;
  logic step;

  // Tick and edge detection. The *_q registers reset high so nothing
  // that is already asserted at reset counts as a fresh edge.
  always_comb begin
    frame_tick = vs & ~vs_q;
    start_hit  = (keycode[7:0] == START_KEY) | (keycode[15:8] == START_KEY);
    start_edge = start_hit & ~start_q;
    req_edge   = battle_req & ~req_q;
    step       = (cnt == CNT_LAST);
  end

  assign state_dbg = state;

  // Scene FSM with fade stepping; all outputs are registered here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_TITLE;
      scene   <= SC_TITLE;
      fade    <= 4'd15;
      move_en <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
      target  <= SC_OVERWORLD;
      vs_q    <= 1'b1;
      start_q <= 1'b1;
      req_q   <= 1'b1;
    end else begin
      vs_q <= vs;
      if (frame_tick) begin
        // Inputs keep sampling during fades so a level held across a
        // transition never produces a late edge.
        start_q <= start_hit;
        req_q   <= battle_req;
        case (state)
          S_TITLE: begin
            if (start_edge) begin
              target  <= SC_OVERWORLD;
              state   <= S_FADE_OUT;
              cnt     <= '0;
              busy    <= 1'b1;
              move_en <= 1'b0;
            end
          end
          S_OVERWORLD: begin
            if (req_edge) begin
              target  <= SC_BATTLE;
              state   <= S_FADE_OUT;
              cnt     <= '0;
              busy    <= 1'b1;
              move_en <= 1'b0;
            end
          end
          S_BATTLE: begin
            if (battle_done) begin
              target  <= SC_OVERWORLD;
              state   <= S_FADE_OUT;
              cnt     <= '0;
              busy    <= 1'b1;
              move_en <= 1'b0;
            end
          end
          S_FADE_OUT: begin
            if (step) begin
              cnt <= '0;
              if (fade != 4'd0) begin
                fade <= fade - 4'd1;
              end else begin
                // Swap only while fully black.
                scene <= target;
                state <= S_FADE_IN;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_FADE_IN: begin
            if (step) begin
              cnt <= '0;
              if (fade != 4'd15) begin
                fade <= fade + 4'd1;
              end else begin
                busy <= 1'b0;
                if (target == SC_BATTLE) begin
                  state   <= S_BATTLE;
                  move_en <= 1'b0;
                end else begin
                  state   <= S_OVERWORLD;
                  move_en <= 1'b1;
                end
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= S_TITLE;
          end
        endcase
      end
    end
  end

endmodule
